// File: rtl/instr_realigner_pkg.sv
// ==================================================================
// instr_realigner_pkg -- shared realigner state and opcode constants
// Revision: 1.0
// ==================================================================
`default_nettype none

package instr_realigner_pkg;

  typedef enum logic [1:0] {
    ALIGNED   = 2'd0,
    UNALIGNED = 2'd1,
    SKIP_LOW  = 2'd2
  } realign_state_e;

  localparam logic [1:0] OPC_FULL = 2'b11;

  // True when the halfword opens a 32-bit instruction.
  function automatic logic is_full(input logic [15:0] hw);
    return hw[1:0] == OPC_FULL;
  endfunction

endpackage

`default_nettype wire

// File: rtl/instr_realigner_out_reg.sv
// ==================================================================
// instr_out_reg -- single-entry valid/ready output register
// Revision: 1.0
// ==================================================================
`default_nettype none

module instr_out_reg (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        flush_i,
  input  logic        in_valid_i,
  input  logic [31:0] in_instr_i,
  input  logic [31:0] in_pc_i,
  input  logic        in_compressed_i,
  input  logic        in_illegal_i,
  input  logic        out_ready_i,
  output logic        out_valid_o,
  output logic [31:0] out_instr_o,
  output logic [31:0] out_pc_o,
  output logic        out_compressed_o,
  output logic        out_illegal_o
);

  logic        valid_q, valid_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc_q, pc_d;
  logic        compressed_q, compressed_d;
  logic        illegal_q, illegal_d;

  // The producer only loads when the entry is empty or draining this cycle.
  always_comb begin
    valid_d      = valid_q;
    instr_d      = instr_q;
    pc_d         = pc_q;
    compressed_d = compressed_q;
    illegal_d    = illegal_q;
    if (valid_q && out_ready_i) begin
      valid_d = 1'b0;
    end
    if (in_valid_i) begin
      valid_d      = 1'b1;
      instr_d      = in_instr_i;
      pc_d         = in_pc_i;
      compressed_d = in_compressed_i;
      illegal_d    = in_illegal_i;
    end
    if (flush_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q      <= 1'b0;
      instr_q      <= 32'h0;
      pc_q         <= 32'h0;
      compressed_q <= 1'b0;
      illegal_q    <= 1'b0;
    end else begin
      valid_q      <= valid_d;
      instr_q      <= instr_d;
      pc_q         <= pc_d;
      compressed_q <= compressed_d;
      illegal_q    <= illegal_d;
    end
  end

  assign out_valid_o      = valid_q;
  assign out_instr_o      = instr_q;
  assign out_pc_o         = pc_q;
  assign out_compressed_o = compressed_q;
  assign out_illegal_o    = illegal_q;

endmodule

`default_nettype wire

// File: rtl/instr_realigner.sv
// ==================================================================
// instr_realigner -- fetch-word to whole-instruction realigner (RV32C)
// Revision: 1.0
// ==================================================================
`default_nettype none

module instr_realigner
  import instr_realigner_pkg::*;
#(
  parameter logic [31:0] BOOT_ADDR = 32'h0000_0080,
  parameter bit          RVC_EN    = 1'b1
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        fetch_valid_i,
  input  logic [31:0] fetch_rdata_i,
  output logic        fetch_ready_o,
  input  logic        flush_i,
  input  logic [31:0] flush_pc_i,
  output logic        instr_valid_o,
  input  logic        instr_ready_i,
  output logic [31:0] instr_o,
  output logic [31:0] pc_o,
  output logic        is_compressed_o,
  output logic        illegal_o
);

  localparam logic [31:0]    RESET_PC    = {BOOT_ADDR[31:1], 1'b0};
  localparam realign_state_e RESET_STATE = BOOT_ADDR[1] ? SKIP_LOW : ALIGNED;

  realign_state_e state_q, state_d;
  logic [15:0]    res_q, res_d;
  logic           res_valid_q, res_valid_d;
  logic [31:0]    pc_q, pc_d;

  logic        can_emit;
  logic        res_compressed;
  logic        fetch_ready;
  logic        emit_valid;
  logic [31:0] emit_instr;
  logic        emit_compressed;
  logic        emit_illegal;

  assign can_emit       = !instr_valid_o || instr_ready_i;
  assign res_compressed = res_valid_q && !is_full(res_q);

  // Kept apart from the datapath so the handshake never depends on fetch data.
  always_comb begin
    fetch_ready = 1'b0;
    if (!flush_i) begin
      unique case (state_q)
        ALIGNED:   fetch_ready = can_emit;
        UNALIGNED: fetch_ready = can_emit && !res_compressed;
        SKIP_LOW:  fetch_ready = 1'b1;
        default:   fetch_ready = 1'b0;
      endcase
    end
  end

  assign fetch_ready_o = fetch_ready && rst_ni;

  always_comb begin
    state_d     = state_q;
    res_d       = res_q;
    res_valid_d = res_valid_q;
    pc_d        = pc_q;
    emit_valid  = 1'b0;
    emit_instr  = 32'h0;
    if (flush_i) begin
      pc_d        = {flush_pc_i[31:1], 1'b0};
      res_valid_d = 1'b0;
      state_d     = flush_pc_i[1] ? SKIP_LOW : ALIGNED;
    end else begin
      unique case (state_q)
        ALIGNED: begin
          if (fetch_valid_i && can_emit) begin
            emit_valid = 1'b1;
            if (is_full(fetch_rdata_i[15:0])) begin
              emit_instr = fetch_rdata_i;
              pc_d       = pc_q + 32'd4;
            end else begin
              emit_instr  = {16'h0, fetch_rdata_i[15:0]};
              res_d       = fetch_rdata_i[31:16];
              res_valid_d = 1'b1;
              pc_d        = pc_q + 32'd2;
              state_d     = UNALIGNED;
            end
          end
        end
        UNALIGNED: begin
          if (res_compressed) begin
            if (can_emit) begin
              emit_valid  = 1'b1;
              emit_instr  = {16'h0, res_q};
              res_valid_d = 1'b0;
              pc_d        = pc_q + 32'd2;
              state_d     = ALIGNED;
            end
          end else if (fetch_valid_i && can_emit) begin
            // Straddling instruction: low half buffered, high half in this word.
            emit_valid = 1'b1;
            emit_instr = {fetch_rdata_i[15:0], res_q};
            res_d      = fetch_rdata_i[31:16];
            pc_d       = pc_q + 32'd4;
          end
        end
        SKIP_LOW: begin
          if (fetch_valid_i) begin
            res_d       = fetch_rdata_i[31:16];
            res_valid_d = 1'b1;
            state_d     = UNALIGNED;
          end
        end
        default: begin
          state_d     = ALIGNED;
          res_valid_d = 1'b0;
        end
      endcase
    end
  end

  assign emit_compressed = emit_instr[1:0] != OPC_FULL;
  assign emit_illegal    = emit_compressed && (RVC_EN == 1'b0);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= RESET_STATE;
      res_q       <= 16'h0;
      res_valid_q <= 1'b0;
      pc_q        <= RESET_PC;
    end else begin
      state_q     <= state_d;
      res_q       <= res_d;
      res_valid_q <= res_valid_d;
      pc_q        <= pc_d;
    end
  end

  instr_out_reg u_out_reg (
    .clk_i            (clk_i),
    .rst_ni           (rst_ni),
    .flush_i          (flush_i),
    .in_valid_i       (emit_valid),
    .in_instr_i       (emit_instr),
    .in_pc_i          (pc_q),
    .in_compressed_i  (emit_compressed),
    .in_illegal_i     (emit_illegal),
    .out_ready_i      (instr_ready_i),
    .out_valid_o      (instr_valid_o),
    .out_instr_o      (instr_o),
    .out_pc_o         (pc_o),
    .out_compressed_o (is_compressed_o),
    .out_illegal_o    (illegal_o)
  );

endmodule

`default_nettype wire

// File: tb/tb_instr_realigner.sv
// ==================================================================
// tb_instr_realigner -- self-checking bench with halfword-queue model
// Revision: 1.0
// ==================================================================
`default_nettype none

module tb_instr_realigner;

  localparam logic [31:0] BOOT = 32'h0000_0080;

  logic        clk = 1'b0;
  logic        rst_ni;
  logic        fetch_valid_i;
  logic [31:0] fetch_rdata_i;
  logic        fetch_ready_o;
  logic        flush_i;
  logic [31:0] flush_pc_i;
  logic        instr_valid_o;
  logic        instr_ready_i;
  logic [31:0] instr_o;
  logic [31:0] pc_o;
  logic        is_compressed_o;
  logic        illegal_o;

  logic        nr_fetch_ready;
  logic        nr_valid;
  logic [31:0] nr_instr;
  logic [31:0] nr_pc;
  logic        nr_c;
  logic        nr_ill;

  always #5 clk = ~clk;

  instr_realigner #(.BOOT_ADDR(BOOT), .RVC_EN(1'b1)) dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .fetch_valid_i(fetch_valid_i), .fetch_rdata_i(fetch_rdata_i), .fetch_ready_o(fetch_ready_o),
    .flush_i(flush_i), .flush_pc_i(flush_pc_i),
    .instr_valid_o(instr_valid_o), .instr_ready_i(instr_ready_i),
    .instr_o(instr_o), .pc_o(pc_o), .is_compressed_o(is_compressed_o), .illegal_o(illegal_o)
  );

  instr_realigner #(.BOOT_ADDR(BOOT), .RVC_EN(1'b0)) dut_nr (
    .clk_i(clk), .rst_ni(rst_ni),
    .fetch_valid_i(fetch_valid_i), .fetch_rdata_i(fetch_rdata_i), .fetch_ready_o(nr_fetch_ready),
    .flush_i(flush_i), .flush_pc_i(flush_pc_i),
    .instr_valid_o(nr_valid), .instr_ready_i(instr_ready_i),
    .instr_o(nr_instr), .pc_o(nr_pc), .is_compressed_o(nr_c), .illegal_o(nr_ill)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s: actual=timeout/unexpected required=event", name);
  endtask

  // Model: fetched halfwords queued with their addresses, cut into instructions.
  logic [47:0] hq[$];
  logic [64:0] eq[$];
  logic [31:0] m_waddr;
  bit          m_skip;

  task automatic m_reset(input logic [31:0] target);
    hq.delete();
    eq.delete();
    m_waddr = {target[31:2], 2'b00};
    m_skip  = target[1];
  endtask

  task automatic m_word(input logic [31:0] w);
    logic [47:0] h0;
    logic [47:0] h1;
    if (!m_skip) hq.push_back({m_waddr, w[15:0]});
    hq.push_back({m_waddr + 32'd2, w[31:16]});
    m_skip  = 1'b0;
    m_waddr = m_waddr + 32'd4;
    while (hq.size() > 0) begin
      h0 = hq[0];
      if (h0[1:0] != 2'b11) begin
        eq.push_back({1'b1, h0[47:16], 16'h0, h0[15:0]});
        void'(hq.pop_front());
      end else if (hq.size() >= 2) begin
        h1 = hq[1];
        eq.push_back({1'b0, h0[47:16], h1[15:0], h0[15:0]});
        void'(hq.pop_front());
        void'(hq.pop_front());
      end else begin
        break;
      end
    end
  endtask

  logic [64:0] e;
  logic [31:0] prev_instr;
  logic [31:0] prev_pc;
  logic        prev_c;
  bit          hold = 1'b0;

  always @(negedge clk) begin
    if (!rst_ni) begin
      m_reset(BOOT);
      hold = 1'b0;
    end else begin
      if (hold) begin
        chk("hold_valid", {31'h0, instr_valid_o}, 32'h1);
        chk("hold_instr", instr_o, prev_instr);
        chk("hold_pc", pc_o, prev_pc);
        chk("hold_c", {31'h0, is_compressed_o}, {31'h0, prev_c});
      end
      if (instr_valid_o && instr_ready_i) begin
        if (eq.size() == 0) begin
          fail_now("spurious_instr");
        end else begin
          e = eq.pop_front();
          chk("instr", instr_o, e[31:0]);
          chk("pc", pc_o, e[63:32]);
          chk("compressed", {31'h0, is_compressed_o}, {31'h0, e[64]});
          chk("illegal_rvc_on", {31'h0, illegal_o}, 32'h0);
          chk("nr_valid", {31'h0, nr_valid}, 32'h1);
          chk("nr_instr", nr_instr, e[31:0]);
          chk("nr_pc", nr_pc, e[63:32]);
          chk("nr_illegal", {31'h0, nr_ill}, {31'h0, e[64]});
        end
      end
      hold       = instr_valid_o && !instr_ready_i && !flush_i;
      prev_instr = instr_o;
      prev_pc    = pc_o;
      prev_c     = is_compressed_o;
      if (flush_i) m_reset(flush_pc_i);
      else if (fetch_valid_i && fetch_ready_o) m_word(fetch_rdata_i);
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [31:0] w);
    int n = 0;
    bit done = 1'b0;
    fetch_valid_i = 1'b1;
    fetch_rdata_i = w;
    while (!done) begin
      @(negedge clk);
      if (fetch_ready_o) done = 1'b1;
      else begin
        n++;
        if (n > 20) begin
          fail_now("fetch_accept");
          done = 1'b1;
        end
      end
      @(posedge clk);
      #1;
    end
    fetch_valid_i = 1'b0;
    fetch_rdata_i = 32'hDEAD_BEEF;
  endtask

  task automatic do_flush(input logic [31:0] t);
    flush_i       = 1'b1;
    flush_pc_i    = t;
    fetch_valid_i = 1'b1;
    @(negedge clk);
    chk("flush_fetch_ready", {31'h0, fetch_ready_o}, 32'h0);
    @(posedge clk);
    #1;
    flush_i       = 1'b0;
    fetch_valid_i = 1'b0;
  endtask

  task automatic drain;
    int n = 0;
    instr_ready_i = 1'b1;
    while ((eq.size() != 0 || instr_valid_o) && n < 50) begin
      tick();
      n++;
    end
    if (n >= 50) fail_now("drain");
  endtask

  logic [31:0] stream [0:9] = '{32'h00A0_0513, 32'h8082_4501, 32'h0513_0001, 32'h1141_00A0,
                                32'hC606_E022, 32'h0000_0013, 32'h0293_4185, 32'h0001_0000,
                                32'h0093_0001, 32'h4505_0113};
  bit stream_done;

  initial begin
    rst_ni        = 1'b0;
    fetch_valid_i = 1'b0;
    fetch_rdata_i = 32'hDEAD_BEEF;
    flush_i       = 1'b0;
    flush_pc_i    = 32'h0;
    instr_ready_i = 1'b1;
    tick();
    chk("rst_valid", {31'h0, instr_valid_o}, 32'h0);
    chk("rst_instr", instr_o, 32'h0);
    chk("rst_pc", pc_o, 32'h0);
    chk("rst_c", {31'h0, is_compressed_o}, 32'h0);
    chk("rst_illegal", {31'h0, illegal_o}, 32'h0);
    chk("rst_fetch_ready", {31'h0, fetch_ready_o}, 32'h0);
    tick();
    rst_ni = 1'b1;
    #1;
    chk("boot_fetch_ready", {31'h0, fetch_ready_o}, 32'h1);

    // Full word straight after boot, visible one cycle after the handshake.
    push_word(32'h0000_0013);
    chk("t1_valid", {31'h0, instr_valid_o}, 32'h1);
    chk("t1_instr", instr_o, 32'h0000_0013);
    chk("t1_pc", pc_o, 32'h80);
    chk("t1_c", {31'h0, is_compressed_o}, 32'h0);
    drain();

    // Two compressed in one word; second needs no fetch.
    do_flush(32'h80);
    push_word(32'h4501_0001);
    chk("t2a_instr", instr_o, 32'h0000_0001);
    chk("t2a_pc", pc_o, 32'h80);
    chk("t2a_fetch_ready", {31'h0, fetch_ready_o}, 32'h0);
    tick();
    chk("t2b_valid", {31'h0, instr_valid_o}, 32'h1);
    chk("t2b_instr", instr_o, 32'h0000_4501);
    chk("t2b_pc", pc_o, 32'h82);
    chk("t2b_c", {31'h0, is_compressed_o}, 32'h1);
    drain();

    // Straddle stitched without a bubble, then leftover residual.
    do_flush(32'h80);
    push_word(32'h0013_0001);
    chk("t3a_instr", instr_o, 32'h0000_0001);
    chk("t3a_pc", pc_o, 32'h80);
    push_word(32'h0000_0000);
    chk("t3b_instr", instr_o, 32'h0000_0013);
    chk("t3b_pc", pc_o, 32'h82);
    chk("t3b_c", {31'h0, is_compressed_o}, 32'h0);
    tick();
    chk("t3c_valid", {31'h0, instr_valid_o}, 32'h1);
    chk("t3c_instr", instr_o, 32'h0000_0000);
    chk("t3c_pc", pc_o, 32'h86);
    chk("t3c_c", {31'h0, is_compressed_o}, 32'h1);
    drain();

    // Halfword-aligned redirect drops the low half.
    do_flush(32'h102);
    push_word(32'hABCD_1234);
    chk("t4_skip_valid", {31'h0, instr_valid_o}, 32'h0);
    tick();
    chk("t4_valid", {31'h0, instr_valid_o}, 32'h1);
    chk("t4_instr", instr_o, 32'h0000_ABCD);
    chk("t4_pc", pc_o, 32'h102);
    drain();

    // Backpressure for three cycles, then gapless follow-on.
    do_flush(32'h80);
    instr_ready_i = 1'b0;
    push_word(32'h0000_0013);
    fetch_valid_i = 1'b1;
    fetch_rdata_i = 32'h0000_0093;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t5_fetch_ready", {31'h0, fetch_ready_o}, 32'h0);
      chk("t5_instr", instr_o, 32'h0000_0013);
      chk("t5_pc", pc_o, 32'h80);
      @(posedge clk);
      #1;
    end
    instr_ready_i = 1'b1;
    @(negedge clk);
    chk("t5_release_ready", {31'h0, fetch_ready_o}, 32'h1);
    @(posedge clk);
    #1;
    fetch_valid_i = 1'b0;
    chk("t5_next_valid", {31'h0, instr_valid_o}, 32'h1);
    chk("t5_next_instr", instr_o, 32'h0000_0093);
    chk("t5_next_pc", pc_o, 32'h84);
    drain();

    // RVC disabled instance flags compressed halfwords.
    do_flush(32'h80);
    push_word(32'h4501_0001);
    chk("t6a_nr_instr", nr_instr, 32'h0000_0001);
    chk("t6a_nr_illegal", {31'h0, nr_ill}, 32'h1);
    chk("t6a_illegal", {31'h0, illegal_o}, 32'h0);
    tick();
    chk("t6b_nr_instr", nr_instr, 32'h0000_4501);
    chk("t6b_nr_illegal", {31'h0, nr_ill}, 32'h1);
    drain();

    // Bit 0 of the target ignored; PC wraps silently.
    do_flush(32'hFFFF_FFFD);
    push_word(32'h0005_0001);
    chk("t7a_pc", pc_o, 32'hFFFF_FFFC);
    tick();
    chk("t7b_instr", instr_o, 32'h0000_0005);
    chk("t7b_pc", pc_o, 32'hFFFF_FFFE);
    push_word(32'h0000_0013);
    chk("t7c_instr", instr_o, 32'h0000_0013);
    chk("t7c_pc", pc_o, 32'h0);
    drain();

    // Mixed stream under irregular backpressure, checked by the model.
    do_flush(32'h202);
    stream_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 10; i++) push_word(stream[i]);
        stream_done = 1'b1;
      end
      begin
        int k = 0;
        while (!stream_done) begin
          instr_ready_i = (k % 3) != 1;
          k++;
          tick();
        end
      end
    join
    drain();

    // Asynchronous reset mid-operation.
    push_word(32'h0013_0001);
    rst_ni = 1'b0;
    #1;
    chk("t9_rst_valid", {31'h0, instr_valid_o}, 32'h0);
    chk("t9_rst_pc", pc_o, 32'h0);
    chk("t9_rst_instr", instr_o, 32'h0);
    tick();
    tick();
    rst_ni = 1'b1;
    push_word(32'h0000_0013);
    chk("t9_boot_instr", instr_o, 32'h0000_0013);
    chk("t9_boot_pc", pc_o, 32'h80);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire

// File: doc/instr_realigner.md
# instr_realigner

Fetch-side instruction realigner that turns a stream of 32-bit aligned fetch words into a stream of whole RISC-V instructions, each with its PC and a compressed flag. It supports mixed 16/32-bit code: it buffers a residual halfword, stitches 32-bit instructions that straddle two fetch words, and handles redirects to halfword-aligned targets. It sits between the instruction-fetch interface and the compressed expander / decode stage. Expansion of 16-bit instructions stays downstream; this block only aligns, tags and buffers.

## Interface
- BOOT_ADDR, 32'h0000_0080: PC of the first instruction after reset; bit 1 honoured, bit 0 ignored.
- RVC_EN, 1: when 0, any halfword with bits[1:0] != 2'b11 is emitted with `illegal_o=1`.
- clk_i  in  1  clock; single clock domain.
- rst_ni  in  1  reset; asynchronous, active-low.
- fetch_valid_i  in  1  fetch word available.
- fetch_rdata_i  in  32  fetch word; address is word-aligned.
- fetch_ready_o  out  1  word consumed this cycle.
- flush_i  in  1  redirect; discards all buffered state.
- flush_pc_i  in  32  redirect target; bit 0 ignored.
- instr_valid_o  out  1  output register holds an instruction.
- instr_ready_i  in  1  downstream accepts.
- instr_o  out  32  aligned instruction; compressed instructions are zero-extended to {16'h0, c}.
- pc_o  out  32  PC of `instr_o`.
- is_compressed_o  out  1  `instr_o[1:0] != 2'b11`.
- illegal_o  out  1  compressed instruction seen with RVC_EN=0.

## Operation
- State is the residual halfword `res_q[15:0]`, `res_valid_q`, next-PC `pc_q`, and the FSM: ALIGNED, UNALIGNED, SKIP_LOW.
- ALIGNED (`res_valid_q=0`), word w accepted:
  - w[1:0]==11: emit w at pc_q; pc_q+=4.
  - Otherwise: emit {16'h0,w[15:0]} at pc_q; res_q=w[31:16]; pc_q+=2; go to UNALIGNED.
- UNALIGNED:
  - res_q[1:0]!=11: emit the residual without consuming a fetch word (`fetch_ready_o=0`); pc_q+=2; go to ALIGNED.
  - res_q[1:0]==11: wait for w; emit {w[15:0],res_q}; res_q=w[31:16]; pc_q+=4; stay in UNALIGNED.
- SKIP_LOW (after a flush or reset with target bit1=1): the next accepted word loads res_q=w[31:16], emits nothing, and goes to UNALIGNED.
- Emission happens only when the output register is empty or is being dequeued in the same cycle (`instr_ready_i & instr_valid_o`). Otherwise the word is not consumed and `fetch_ready_o=0`.
- Flush:
  - Highest priority; clears `instr_valid_o` and `res_valid_q`.
  - Sets pc_q={flush_pc_i[31:1],1'b0}.
  - State becomes SKIP_LOW if flush_pc_i[1]=1, otherwise ALIGNED.
  - `fetch_ready_o=0` during the flush cycle; any word presented then is dropped by the fetch unit.
- Width rules: PC arithmetic is modulo 2^32, and wrap from 32'hFFFF_FFFE to 0 is silent.

## Timing
- Reset values:
  - `instr_valid_o=0`, `instr_o=0`, `pc_o=0`, `is_compressed_o=0`, `illegal_o=0`, `fetch_ready_o=0`.
  - pc_q=BOOT_ADDR; state ALIGNED, or SKIP_LOW if BOOT_ADDR[1].
- Latency: one cycle from fetch handshake to `instr_valid_o`. A residual compressed instruction is emitted one cycle after its predecessor, with no fetch needed.
- Throughput: one instruction per cycle while downstream is ready. A straddling 32-bit instruction costs no bubble if the next word is available.
- Outputs are registered and held stable while `instr_valid_o & !instr_ready_i`.
- `fetch_ready_o` is combinational from state, `instr_ready_i` and `flush_i`. It has no path from `fetch_rdata_i`.
- Reset asserted mid-operation clears everything asynchronously. The first word after deassertion is treated as a fresh BOOT_ADDR fetch.

## Structure
- Shared core package: `realign_state_e` enum (ALIGNED, UNALIGNED, SKIP_LOW) and `OPC_FULL = 2'b11` constant.
- Natural sub-module: `instr_out_reg`, a single-entry valid/ready output register carrying {instr, pc, is_compressed, illegal}. The realigner FSM stays in the top module.

## Test plan
- Reset with BOOT_ADDR=0x80; word 0x00000013 -> instr 0x00000013, pc 0x80, is_compressed=0, one cycle after the handshake.
- Word 0x45010001 -> instr 0x00000001 @0x80, then 0x00004501 @0x82; `fetch_ready_o=0` on the second cycle.
- Words 0x00130001, 0x00000000 -> 0x00000001 @0x80, then 0x00000013 @0x82 stitched; residual 0x0000 then emitted @0x86.
- Flush to 0x102, word 0xABCD1234 -> low half dropped; 0x0000ABCD emitted @0x102.
- `instr_ready_i` held low 3 cycles with a pending 0x00000013 -> outputs stable and `fetch_ready_o=0` throughout; release -> next instruction follows with no gap.
- RVC_EN=0, word 0x45010001 -> instr 0x00000001, illegal_o=1.
